// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core, loader and memory signals shared by the arbiter and its environment
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              cpu_rd, cpu_wr, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              ldr_req, ldr_we, ldr_done;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
  logic              mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, ldr_rdata, ldr_done, mem_addr, mem_wdata, mem_rd, mem_wr
  );
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, ldr_rdata, ldr_done, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises core and loader accesses to a fixed-latency unified memory.
// Define MEM_ARB_STARVE_GUARD_EN to force a loader grant after STARVE_LIM contended core grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q, state_d;
  logic              owner_q, wr_q, cpu_req, grant, grant_ldr, last;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, cpu_rdata_q, ldr_rdata_q;
  if (MEM_LAT < 1 || STARVE_LIM < 1) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT and STARVE_LIM must be >= 1");
  end
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] starve_q;
  assign grant_ldr = bus.ldr_req & (~cpu_req | (starve_q == SW'(STARVE_LIM)));
  // only core grants won over a waiting loader count towards starvation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_q <= '0;
    else if (state_q == IDLE)
      starve_q <= (!bus.ldr_req || grant_ldr) ? '0 : cpu_req ? starve_q + 1'b1 : starve_q;
`else
  assign grant_ldr = bus.ldr_req & ~cpu_req;
`endif
  always_comb begin
    cpu_req = bus.cpu_rd | bus.cpu_wr;
    grant   = (state_q == IDLE) & (cpu_req | bus.ldr_req);
    last    = (state_q == BUSY) & (cnt_q == '0);
    state_d = state_q == IDLE ? (grant ? BUSY : IDLE) :
              state_q == BUSY ? (last ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= grant_ldr;
        wr_q    <= grant_ldr ? bus.ldr_we : bus.cpu_wr;
        addr_q  <= grant_ldr ? bus.ldr_addr : bus.cpu_addr;
        wdata_q <= grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
        cnt_q   <= CW'(MEM_LAT - 1);
      end else if (state_q == BUSY && !last) cnt_q <= cnt_q - 1'b1;
      if (last && !wr_q && owner_q) ldr_rdata_q <= bus.mem_rdata;
      if (last && !wr_q && !owner_q) cpu_rdata_q <= bus.mem_rdata;
    end
  assign bus.mem_rd    = (state_q == BUSY) & ~wr_q;
  assign bus.mem_wr    = (state_q == BUSY) & wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.ldr_done  = (state_q == DONE) & owner_q;
  assign bus.cpu_stall = cpu_req & ~((state_q == DONE) & ~owner_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, timing, reset and loader starvation behaviour
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = 0; bus.ldr_wdata = 0;
    bus.mem_rdata = 0;
    #12;
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_ldr_done", 32'(bus.ldr_done), 0);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    tick();
    rst_n = 1;
    tick();
    // core read of 0x40
    bus.cpu_rd = 1; bus.cpu_addr = 32'h40; bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_stall_idle", 32'(bus.cpu_stall), 1);
    chk("rd_strobe_idle", 32'(bus.mem_rd), 0);
    tick();
    chk("rd_strobe1", 32'(bus.mem_rd), 1);
    chk("rd_addr", bus.mem_addr, 32'h40);
    chk("rd_stall1", 32'(bus.cpu_stall), 1);
    tick();
    chk("rd_strobe2", 32'(bus.mem_rd), 1);
    chk("rd_stall2", 32'(bus.cpu_stall), 1);
    tick();
    chk("rd_done_strobe", 32'(bus.mem_rd), 0);
    chk("rd_done_stall", 32'(bus.cpu_stall), 0);
    chk("rd_data", bus.cpu_rdata, 32'hDEADBEEF);
    chk("rd_no_ldr_done", 32'(bus.ldr_done), 0);
    bus.cpu_rd = 0;
    tick();
    chk("rd_idle_strobe", 32'(bus.mem_rd), 0);
    // loader write with core idle
    bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 32'h100; bus.ldr_wdata = 32'h12345678;
    tick();
    chk("lw_strobe1", 32'(bus.mem_wr), 1);
    chk("lw_rd_low", 32'(bus.mem_rd), 0);
    chk("lw_addr", bus.mem_addr, 32'h100);
    chk("lw_wdata", bus.mem_wdata, 32'h12345678);
    chk("lw_done_early", 32'(bus.ldr_done), 0);
    tick();
    chk("lw_strobe2", 32'(bus.mem_wr), 1);
    tick();
    chk("lw_done", 32'(bus.ldr_done), 1);
    chk("lw_strobe_off", 32'(bus.mem_wr), 0);
    bus.ldr_req = 0;
    tick();
    chk("lw_done_pulse", 32'(bus.ldr_done), 0);
    chk("lw_cpu_rdata_kept", bus.cpu_rdata, 32'hDEADBEEF);
    // simultaneous core write and loader read: core wins
    bus.cpu_wr = 1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'hCAFEF00D;
    bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 32'h200; bus.mem_rdata = 32'h11112222;
    tick();
    chk("cw_strobe", 32'(bus.mem_wr), 1);
    chk("cw_addr", bus.mem_addr, 32'h80);
    chk("cw_wdata", bus.mem_wdata, 32'hCAFEF00D);
    tick();
    tick();
    chk("cw_done_stall", 32'(bus.cpu_stall), 0);
    chk("cw_no_ldr_done", 32'(bus.ldr_done), 0);
    chk("cw_ldr_rdata_kept", bus.ldr_rdata, 0);
    bus.cpu_wr = 0;
    tick();
    chk("lr_idle_strobe", 32'(bus.mem_rd), 0);
    bus.mem_rdata = 32'h55AA55AA;
    tick();
    chk("lr_strobe", 32'(bus.mem_rd), 1);
    chk("lr_addr", bus.mem_addr, 32'h200);
    tick();
    tick();
    chk("lr_done", 32'(bus.ldr_done), 1);
    chk("lr_data", bus.ldr_rdata, 32'h55AA55AA);
    chk("lr_cpu_rdata_kept", bus.cpu_rdata, 32'hDEADBEEF);
    bus.ldr_req = 0;
    tick();
    // cpu_rd and cpu_wr together act as a write
    bus.cpu_rd = 1; bus.cpu_wr = 1; bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'h0BADF00D;
    bus.mem_rdata = 32'h99999999;
    tick();
    chk("rw_wr", 32'(bus.mem_wr), 1);
    chk("rw_rd", 32'(bus.mem_rd), 0);
    chk("rw_wdata", bus.mem_wdata, 32'h0BADF00D);
    tick();
    tick();
    chk("rw_rdata_kept", bus.cpu_rdata, 32'hDEADBEEF);
    bus.cpu_rd = 0; bus.cpu_wr = 0;
    tick();
    // continuous core reads while the loader waits
    bus.cpu_rd = 1; bus.cpu_addr = 32'h40;
    bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 32'h300;
    bus.mem_rdata = 32'h0000ABCD;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      logic ldr_turn = (i == 4);
`else
      logic ldr_turn = 1'b0;
`endif
      tick();
      chk($sformatf("starve_addr_%0d", i), bus.mem_addr, ldr_turn ? 32'h300 : 32'h40);
      tick();
      tick();
      chk($sformatf("starve_done_%0d", i), 32'(bus.ldr_done), 32'(ldr_turn));
      tick();
    end
    bus.cpu_rd = 0; bus.ldr_req = 0;
    tick();
    tick();
    // reset asserted mid-access
    bus.cpu_rd = 1; bus.cpu_addr = 32'h40; bus.mem_rdata = 32'h77777777;
    tick();
    chk("rb_strobe", 32'(bus.mem_rd), 1);
    rst_n = 0;
    #1;
    chk("rb_strobe_drop", 32'(bus.mem_rd), 0);
    chk("rb_wr_low", 32'(bus.mem_wr), 0);
    chk("rb_addr", bus.mem_addr, 0);
    chk("rb_cpu_rdata", bus.cpu_rdata, 0);
    chk("rb_stall_eq", 32'(bus.cpu_stall), 1);
    bus.cpu_rd = 0;
    tick();
    rst_n = 1;
    tick();
    tick();
    chk("ra_strobe", 32'(bus.mem_rd), 0);
    chk("ra_ldr_done", 32'(bus.ldr_done), 0);
    chk("ra_cpu_rdata", bus.cpu_rdata, 0);
    chk("ra_ldr_rdata", bus.ldr_rdata, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single unified instruction/data memory of the multicycle core between the core's control-driven memory accesses and an external program-loader port. The core's fetch and load/store states drive a request here. The arbiter serialises accesses against a fixed-latency memory, stalls the core's state register until its access completes, and returns read data. The loader uses the memory only when the core is not accessing it, subject to a compile-time starvation guard.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles memory strobe held per access (≥1)
- STARVE_LIM, 4, consecutive core grants tolerated while loader waits (guard only, ≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_rd  in  1  core MemRead request
- cpu_wr  in  1  core MemWrite request
- cpu_addr  in  ADDR_W  core address (IorD-muxed)
- cpu_wdata  in  DATA_W  core store data
- cpu_rdata  out  DATA_W  registered read data to core
- cpu_stall  out  1  freeze core state register/PC/IR
- ldr_req  in  1  loader request
- ldr_we  in  1  loader write (1) / read (0)
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_rdata  out  DATA_W  registered read data to loader
- ldr_done  out  1  one-cycle completion pulse for loader
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, valid in last strobe cycle

## Operation
- States: IDLE, BUSY, DONE. Owner register: CPU or LDR.
- IDLE: core request is cpu_rd|cpu_wr. If core and loader both request, the core wins, unless the guard forces the loader. Winner's addr/wdata/op are latched, owner set, latency counter loaded with MEM_LAT-1, go BUSY. No request: stay IDLE.
- cpu_rd and cpu_wr both high: treated as write.
- BUSY: mem_rd or mem_wr driven from the latched op; mem_addr/mem_wdata driven from the latches. Counter decrements each cycle. At count 0, mem_rdata is captured into the owner's rdata register (reads only) and the state goes to DONE.
- DONE: strobes low. ldr_done=1 if owner is LDR. cpu_stall=0 if owner is CPU. Go IDLE.
- cpu_stall = (cpu_rd|cpu_wr) & ~(state==DONE & owner==CPU). This is combinational, so a fresh core request stalls in the same cycle.
- Requesters must drop or change their request in the cycle after completion. A still-asserted request in IDLE is granted again as a new access.
- Loader inputs must be held stable until ldr_done. Loader reads do not alter cpu_rdata, and core reads do not alter ldr_rdata.
- Reset (any time, including mid-BUSY): state IDLE, owner CPU, counters 0, all rdata registers 0. mem_rd, mem_wr, ldr_done, mem_addr and mem_wdata go to 0. The in-flight access is abandoned. cpu_stall follows its equation.

## Timing
- Request sampled at edge N (IDLE). Strobe high cycles N+1..N+MEM_LAT. DONE in cycle N+MEM_LAT+1, with rdata valid from that cycle. IDLE at N+MEM_LAT+2.
- Occupancy per access: MEM_LAT+2 cycles. Back-to-back accesses have no overlap.
- Core sees cpu_stall high for MEM_LAT+1 cycles per uncontended access, plus the full duration of any loader access already in progress.
- ldr_done is exactly one cycle wide.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: a starvation counter increments on each core grant made while ldr_req=1. It clears on any loader grant, or when ldr_req=0 in IDLE. When the counter reaches STARVE_LIM, the next IDLE arbitration grants the loader even if the core requests.
- Not defined: strict core priority, and the loader is served only when the core is idle. No counter logic exists.

## Test plan
- Core read, MEM_LAT=2: cpu_rd=1, addr 0x40, memory returns 0xDEADBEEF → mem_rd high 2 cycles, cpu_stall high 3 cycles, cpu_rdata=0xDEADBEEF in DONE.
- Loader write 0x12345678 to 0x100 with core idle → mem_wr high 2 cycles, mem_wdata=0x12345678, ldr_done single pulse at cycle N+3.
- Core write and loader read asserted in the same IDLE cycle → core served first. Loader is granted in the following IDLE, and ldr_rdata is unaffected by the core transaction.
- Guard on, STARVE_LIM=4, core requesting continuously while ldr_req=1 → 4 core grants, then a loader grant, counter cleared. Guard off → loader never granted.
- rst_n pulled low during BUSY → mem_rd/mem_wr drop immediately. After release: IDLE, cpu_rdata=0, no ldr_done.
- cpu_rd=cpu_wr=1 → write performed, cpu_rdata unchanged.
